// File: rtl/riscv_data_axi_lite_bridge.sv
// Single-outstanding bridge from the core's req/gnt/rvalid data port to an AXI4-Lite master.
// One transaction in flight; the response comes back as a registered one-cycle rvalid_o pulse.
module riscv_data_axi_lite_bridge #(
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic [2:0]              awprot_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  output logic [ADDR_WIDTH-1:0]   araddr_o,
  output logic [2:0]              arprot_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic                    rvalid_i,
  output logic                    rready_o
);
  localparam int STRB_WIDTH = DATA_WIDTH/8;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;

  logic [2:0]            state;
  logic                  aw_pend, w_pend;
  logic                  aw_left, w_left;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] be_q;
  logic                  rsp_vld, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_data;

  // rst_ni term keeps gnt_o low while reset holds the FSM in IDLE
  assign gnt_o   = req_i && rst_ni && (state == IDLE);
  assign aw_left = aw_pend && !awready_i;
  assign w_left  = w_pend && !wready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      aw_pend  <= 1'b0;
      w_pend   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rsp_vld  <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_data <= '0;
    end else begin
      rsp_vld <= 1'b0;
      case (state)
        IDLE: if (gnt_o) begin
          addr_q  <= addr_i;
          be_q    <= be_i;
          wdata_q <= wdata_i;
          if (we_i) begin
            state   <= WR_REQ;
            aw_pend <= 1'b1;
            w_pend  <= 1'b1;
          end else begin
            state <= RD_REQ;
          end
        end
        WR_REQ: begin
          aw_pend <= aw_left;
          w_pend  <= w_left;
          if (!aw_left && !w_left) state <= WR_RESP;
        end
        WR_RESP: if (bvalid_i) begin
          rsp_vld  <= 1'b1;
          rsp_err  <= bresp_i[1];
          rsp_data <= '0;
          state    <= IDLE;
        end
        RD_REQ: if (arready_i) state <= RD_RESP;
        RD_RESP: if (rvalid_i) begin
          rsp_vld  <= 1'b1;
          rsp_err  <= rresp_i[1];
          rsp_data <= rdata_i;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign awaddr_o  = addr_q;
  assign araddr_o  = addr_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = be_q;
  assign awprot_o  = 3'b000;
  assign arprot_o  = 3'b000;
  assign awvalid_o = aw_pend;
  assign wvalid_o  = w_pend;
  assign arvalid_o = (state == RD_REQ);
  assign bready_o  = (state == WR_RESP);
  assign rready_o  = (state == RD_RESP);
  assign rvalid_o  = rsp_vld;
  assign err_o     = rsp_err;
  assign rdata_o   = rsp_data;
endmodule

// File: tb/tb_riscv_data_axi_lite_bridge.sv
// Bench for riscv_data_axi_lite_bridge: directed scenarios plus random traffic against a
// delay-configurable AXI4-Lite slave and a word-level memory reference model.
module tb_riscv_data_axi_lite_bridge;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic        gnt_o;
  logic [33:0] addr_i = '0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic [33:0] awaddr_o, araddr_o;
  logic [2:0]  awprot_o, arprot_o;
  logic        awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o;
  logic        awready_i = 1'b0, wready_i = 1'b0, bvalid_i = 1'b0, arready_i = 1'b0, rvalid_i = 1'b0;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic [1:0]  bresp_i = '0, rresp_i = '0;
  logic [31:0] rdata_i = '0;

  riscv_data_axi_lite_bridge #(.ADDR_WIDTH(34), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .awaddr_o(awaddr_o), .awprot_o(awprot_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .araddr_o(araddr_o), .arprot_o(arprot_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // reference model memory (core view) and slave memory (AXI view)
  logic [31:0] mem_m [256];
  logic [31:0] smem  [256];

  // slave configuration and state
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  cur_resp = 2'b00;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit          aw_got, w_got, b_pend;
  logic [1:0]  b_rsp;
  logic [33:0] s_awaddr, last_awaddr, last_araddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] rq [$];
  logic [1:0]  rrq [$];
  bit          p_aw_wait, p_w_wait, p_ar_wait;
  logic [33:0] p_awaddr, p_araddr;
  logic [31:0] p_wdata;
  logic [3:0]  p_wstrb;

  task automatic slave_clear();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; b_pend = 0;
    rq.delete(); rrq.delete();
    p_aw_wait = 0; p_w_wait = 0; p_ar_wait = 0;
    awready_i = 0; wready_i = 0; bvalid_i = 0; arready_i = 0; rvalid_i = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
  endtask

  // Runs at each falling edge: valids/readies chosen here are what the next rising edge sees.
  task automatic slave_step();
    if (p_aw_wait) begin
      checks++;
      if (awvalid_o !== 1'b1 || awaddr_o !== p_awaddr) begin
        failures++; $display("FAIL aw_stable got v=%0b a=%h want v=1 a=%h", awvalid_o, awaddr_o, p_awaddr);
      end
    end
    if (p_w_wait) begin
      checks++;
      if (wvalid_o !== 1'b1 || wdata_o !== p_wdata || wstrb_o !== p_wstrb) begin
        failures++; $display("FAIL w_stable got v=%0b d=%h s=%h want v=1 d=%h s=%h", wvalid_o, wdata_o, wstrb_o, p_wdata, p_wstrb);
      end
    end
    if (p_ar_wait) begin
      checks++;
      if (arvalid_o !== 1'b1 || araddr_o !== p_araddr) begin
        failures++; $display("FAIL ar_stable got v=%0b a=%h want v=1 a=%h", arvalid_o, araddr_o, p_araddr);
      end
    end
    // R
    if (rq.size() > 0) begin
      if (r_cnt >= r_dly) begin rvalid_i = 1; rdata_i = rq[0]; rresp_i = rrq[0]; end
      else begin rvalid_i = 0; r_cnt++; end
    end else rvalid_i = 0;
    if (rvalid_i && rready_o) begin void'(rq.pop_front()); void'(rrq.pop_front()); r_cnt = 0; end
    // B
    if (b_pend) begin
      if (b_cnt >= b_dly) begin bvalid_i = 1; bresp_i = b_rsp; end
      else begin bvalid_i = 0; b_cnt++; end
    end else bvalid_i = 0;
    if (bvalid_i && bready_o) begin b_pend = 0; b_cnt = 0; end
    // AW / W
    if (awvalid_o) begin
      if (aw_cnt >= aw_dly) awready_i = 1; else begin awready_i = 0; aw_cnt++; end
    end else begin awready_i = 0; aw_cnt = 0; end
    if (awvalid_o && awready_i) begin aw_got = 1; s_awaddr = awaddr_o; end
    if (wvalid_o) begin
      if (w_cnt >= w_dly) wready_i = 1; else begin wready_i = 0; w_cnt++; end
    end else begin wready_i = 0; w_cnt = 0; end
    if (wvalid_o && wready_i) begin w_got = 1; s_wdata = wdata_o; s_wstrb = wstrb_o; end
    if (aw_got && w_got) begin
      aw_got = 0; w_got = 0;
      if (!cur_resp[1])
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) smem[s_awaddr[9:2]][8*b +: 8] = s_wdata[8*b +: 8];
      b_pend = 1; b_rsp = cur_resp; last_awaddr = s_awaddr;
    end
    // AR
    if (arvalid_o) begin
      if (ar_cnt >= ar_dly) arready_i = 1; else begin arready_i = 0; ar_cnt++; end
    end else begin arready_i = 0; ar_cnt = 0; end
    if (arvalid_o && arready_i) begin
      rq.push_back(smem[araddr_o[9:2]]); rrq.push_back(cur_resp); last_araddr = araddr_o;
    end
    p_aw_wait = awvalid_o && !awready_i; p_awaddr = awaddr_o;
    p_w_wait  = wvalid_o && !wready_i;   p_wdata = wdata_o; p_wstrb = wstrb_o;
    p_ar_wait = arvalid_o && !arready_i; p_araddr = araddr_o;
  endtask

  initial begin
    slave_clear();
    forever begin
      @(negedge clk_i);
      if (rst_ni) slave_step();
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Presents a request at the current falling edge, waits for grant, returns one edge later with req dropped.
  task automatic issue(input logic we, input logic [33:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic [1:0] rsp);
    int n = 0;
    cur_resp = rsp; we_i = we; addr_i = a; be_i = be; wdata_i = wd; req_i = 1;
    #1;
    while (!gnt_o && n < 100) begin @(negedge clk_i); #1; n++; end
    checks++;
    if (gnt_o !== 1'b1) begin failures++; $display("FAIL grant_timeout got=%0b want=1", gnt_o); end
    @(negedge clk_i);
    req_i = 0;
  endtask

  task automatic wait_rsp(input int start, output logic [31:0] rd, output logic er, output int lat);
    lat = start;
    while (!rvalid_o && lat < start + 200) begin @(negedge clk_i); lat++; end
    checks++;
    if (rvalid_o !== 1'b1) begin failures++; $display("FAIL rsp_timeout got=%0b want=1", rvalid_o); end
    rd = rdata_o; er = err_o;
  endtask

  task automatic test_reset();
    rst_ni = 0; req_i = 1; we_i = 1; addr_i = 34'h3_FFFF_FFFF; be_i = 4'hF; wdata_i = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if ({gnt_o, rvalid_o, err_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o} !== 8'h00) begin
      failures++; $display("FAIL reset_ctrl got=%b want=00000000",
        {gnt_o, rvalid_o, err_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o});
    end
    checks++;
    if (rdata_o !== 32'h0 || awaddr_o !== 34'h0 || araddr_o !== 34'h0 || wdata_o !== 32'h0 ||
        wstrb_o !== 4'h0 || awprot_o !== 3'h0 || arprot_o !== 3'h0) begin
      failures++; $display("FAIL reset_data got rd=%h aw=%h ar=%h wd=%h ws=%h want all zero",
        rdata_o, awaddr_o, araddr_o, wdata_o, wstrb_o);
    end
    req_i = 0;
    @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i);
  endtask

  task automatic test_read();
    logic [31:0] rd; logic er; int lat;
    smem[1] = 32'hDEAD_BEEF; mem_m[1] = 32'hDEAD_BEEF;
    issue(1'b0, 34'h0_1000_0004, 4'hF, 32'h0, 2'b00);
    checks++;
    if (arvalid_o !== 1'b1 || araddr_o !== 34'h0_1000_0004 || arprot_o !== 3'b000) begin
      failures++; $display("FAIL read_ar got v=%0b a=%h p=%0d want v=1 a=010000004 p=0", arvalid_o, araddr_o, arprot_o);
    end
    wait_rsp(1, rd, er, lat);
    checks++;
    if (lat !== 3 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      failures++; $display("FAIL read_rsp got lat=%0d d=%h e=%0b want lat=3 d=deadbeef e=0", lat, rd, er);
    end
    @(negedge clk_i);
    checks++;
    if (rvalid_o !== 1'b0) begin failures++; $display("FAIL rvalid_pulse got=%0b want=0", rvalid_o); end
  endtask

  task automatic test_write_staggered();
    logic [31:0] rd; logic er; int lat;
    logic [4:0] exp_aw, exp_w;
    exp_aw = 5'b01111;
    exp_w  = 5'b00011;
    aw_dly = 3; w_dly = 1;
    issue(1'b1, 34'h2_0000_0010, 4'b0011, 32'h1234_5678, 2'b00);
    mem_m[4][15:0] = 16'h5678;
    checks++;
    if (wstrb_o !== 4'b0011 || wdata_o !== 32'h1234_5678 || awaddr_o !== 34'h2_0000_0010) begin
      failures++; $display("FAIL write_fields got s=%b d=%h a=%h want s=0011 d=12345678 a=200000010", wstrb_o, wdata_o, awaddr_o);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (awvalid_o !== exp_aw[i] || wvalid_o !== exp_w[i]) begin
        failures++; $display("FAIL write_valids cyc=%0d got aw=%0b w=%0b want aw=%0b w=%0b", i + 1, awvalid_o, wvalid_o, exp_aw[i], exp_w[i]);
      end
      if (i < 4) @(negedge clk_i);
    end
    wait_rsp(5, rd, er, lat);
    checks++;
    if (lat !== 6 || rd !== 32'h0 || er !== 1'b0) begin
      failures++; $display("FAIL write_rsp got lat=%0d d=%h e=%0b want lat=6 d=0 e=0", lat, rd, er);
    end
    aw_dly = 0; w_dly = 0;
    issue(1'b0, 34'h2_0000_0010, 4'hF, 32'h0, 2'b00);
    wait_rsp(1, rd, er, lat);
    checks++;
    if (rd !== mem_m[4]) begin failures++; $display("FAIL write_readback got=%h want=%h", rd, mem_m[4]); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    issue(1'b0, 34'h0_0000_001C, 4'hF, 32'h0, 2'b10);
    wait_rsp(1, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== mem_m[7]) begin
      failures++; $display("FAIL slverr_read got e=%0b d=%h want e=1 d=%h", er, rd, mem_m[7]);
    end
    issue(1'b1, 34'h0_0000_0020, 4'hF, 32'hCAFE_F00D, 2'b11);
    wait_rsp(1, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL decerr_write got e=%0b d=%h want e=1 d=0", er, rd);
    end
    issue(1'b0, 34'h0_0000_0020, 4'hF, 32'h0, 2'b00);
    wait_rsp(1, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== mem_m[8]) begin
      failures++; $display("FAIL decerr_nowrite got e=%0b d=%h want e=0 d=%h", er, rd, mem_m[8]);
    end
  endtask

  task automatic test_busy();
    logic [31:0] rd; logic er; int lat; int n;
    r_dly = 5; cur_resp = 2'b00;
    we_i = 0; addr_i = 34'h1_0000_0028; be_i = 4'hF; req_i = 1;
    #1;
    checks++;
    if (gnt_o !== 1'b1) begin failures++; $display("FAIL busy_first_gnt got=%0b want=1", gnt_o); end
    @(negedge clk_i);
    addr_i = 34'h1_0000_002C;
    n = 1;
    #1;
    while (!rvalid_o && n < 50) begin
      checks++;
      if (gnt_o !== 1'b0) begin failures++; $display("FAIL busy_holdoff cyc=%0d got=%0b want=0", n, gnt_o); end
      @(negedge clk_i); #1; n++;
    end
    checks++;
    if (n !== 8 || gnt_o !== 1'b1 || rdata_o !== mem_m[10]) begin
      failures++; $display("FAIL busy_b2b got lat=%0d g=%0b d=%h want lat=8 g=1 d=%h", n, gnt_o, rdata_o, mem_m[10]);
    end
    r_dly = 0;
    @(negedge clk_i);
    req_i = 0;
    wait_rsp(1, rd, er, lat);
    checks++;
    if (lat !== 3 || rd !== mem_m[11]) begin
      failures++; $display("FAIL busy_second got lat=%0d d=%h want lat=3 d=%h", lat, rd, mem_m[11]);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd; logic er; int lat;
    aw_dly = 10; w_dly = 10;
    issue(1'b1, 34'h0_0000_0024, 4'hF, 32'h0BAD_0BAD, 2'b00);
    checks++;
    if (awvalid_o !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%0b want=1", awvalid_o); end
    #2 rst_ni = 0;
    #1;
    checks++;
    if ({gnt_o, rvalid_o, err_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o} !== 8'h00 ||
        awaddr_o !== 34'h0 || wdata_o !== 32'h0 || wstrb_o !== 4'h0 || rdata_o !== 32'h0) begin
      failures++; $display("FAIL midrst_outputs got ctl=%b aw=%h wd=%h ws=%h want all zero",
        {gnt_o, rvalid_o, err_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o}, awaddr_o, wdata_o, wstrb_o);
    end
    slave_clear();
    @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i);
    issue(1'b0, 34'h0_0000_0024, 4'hF, 32'h0, 2'b00);
    wait_rsp(1, rd, er, lat);
    checks++;
    if (lat !== 3 || rd !== mem_m[9] || er !== 1'b0) begin
      failures++; $display("FAIL midrst_read got lat=%0d d=%h e=%0b want lat=3 d=%h e=0", lat, rd, er, mem_m[9]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, exp_rd; logic er; int lat, exp_lat;
    logic we; logic [7:0] idx; logic [33:0] a; logic [3:0] be; logic [1:0] rsp; int r;
    for (int t = 0; t < 1000; t++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      we = 1'($urandom_range(0, 1)); idx = 8'($urandom_range(0, 255));
      a = {24'($urandom), idx, 2'($urandom)}; be = 4'($urandom); wd = $urandom;
      r = $urandom_range(0, 7);
      rsp = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : (r == 2) ? 2'b01 : 2'b00;
      if (we) begin
        exp_rd = 32'h0;
        exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
        if (!rsp[1])
          for (int b = 0; b < 4; b++) if (be[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_rd = mem_m[idx];
        exp_lat = 3 + ar_dly + r_dly;
      end
      issue(we, a, be, wd, rsp);
      wait_rsp(1, rd, er, lat);
      checks++;
      if (rd !== exp_rd || er !== rsp[1] || lat !== exp_lat) begin
        failures++; $display("FAIL rand_rsp t=%0d we=%0b got d=%h e=%0b lat=%0d want d=%h e=%0b lat=%0d",
          t, we, rd, er, lat, exp_rd, rsp[1], exp_lat);
      end
      checks++;
      if ((we ? last_awaddr : last_araddr) !== a) begin
        failures++; $display("FAIL rand_addr t=%0d got=%h want=%h", t, we ? last_awaddr : last_araddr, a);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = $urandom;
      smem[i] = v; mem_m[i] = v;
    end
    test_reset();
    test_read();
    test_write_staggered();
    test_errors();
    test_busy();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
